// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
//
// Central stall/flush sequencer for a 5-stage IF/ID/EX/MEM/WB pipeline.
//
// The four stall sources are merged into one control vector by strict
// priority:
//   HALT > data-memory wait > EX busy (mul/div) > mispredict > data hazard
// Control outputs are combinational from the current state and inputs, so
// the pipeline sees a zero-latency response. State, the memory-wait
// watchdog and the performance counters update on the rising clk edge.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   is_data_hazard      decode data hazard
//   branch_mispredict   mispredict for the instruction in EX
//   muldiv_start        EX holds a multi-cycle mul/div
//   muldiv_done         mul/div result valid (level)
//   dmem_req, dmem_ack  MEM access present / completing this cycle
//   stall_*             hold the named stage register
//   bubble_*            load a NOP into the named stage register
//   flush_fetch/decode  squash IF/ID contents
//   dmem_timeout        sticky watchdog error flag
//   stall_cycles        saturating count of cycles with stall_fetch=1
//   flush_events        saturating count of mispredict flushes
// ---------------------------------------------------------------------------
module pipeline_stall_controller #(
  parameter int DMEM_TIMEOUT = 255,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 is_data_hazard,
  input  logic                 branch_mispredict,
  input  logic                 muldiv_start,
  input  logic                 muldiv_done,
  input  logic                 dmem_req,
  input  logic                 dmem_ack,
  output logic                 stall_fetch,
  output logic                 stall_decode,
  output logic                 stall_execute,
  output logic                 stall_memory,
  output logic                 bubble_execute,
  output logic                 bubble_memory,
  output logic                 bubble_writeback,
  output logic                 flush_fetch,
  output logic                 flush_decode,
  output logic                 dmem_timeout,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_events
);

  localparam int WCW = $clog2(DMEM_TIMEOUT + 1);
  // Counter value at the start of the last permitted wait cycle.
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(DMEM_TIMEOUT - 1);
  localparam logic [WCW-1:0] WAIT_MAX  = WCW'(DMEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_WAIT = 2'd1,
    ST_HALT    = 2'd2
  } state_e;

  typedef struct packed {
    logic sf, sd, se, sm;  // stalls
    logic be, bm, bw;      // bubbles
    logic ff, fd;          // flushes
  } ctrl_t;

  state_e           state_q;
  logic [WCW-1:0]   wait_cnt_q;
  logic             dmem_timeout_q;
  logic [CNT_WIDTH-1:0] stall_cycles_q;
  logic [CNT_WIDTH-1:0] flush_events_q;

  logic  mem_wait;
  logic  ex_busy;
  logic  halt_trig;
  ctrl_t ctrl;

  assign mem_wait = dmem_req & ~dmem_ack;

  // In RUN a start without done stalls EX in the same cycle it appears;
  // a start that completes in one cycle never stalls.
  assign ex_busy = ((state_q == ST_MD_WAIT) & ~muldiv_done) |
                   ((state_q == ST_RUN) & muldiv_start & ~muldiv_done);

  // The DMEM_TIMEOUT-th consecutive wait cycle moves to HALT on its edge.
  // An ack in that cycle clears mem_wait, so it counts as a completion.
  assign halt_trig = mem_wait & (wait_cnt_q == WAIT_LAST);

  // ---------------------------------------------------------------------
  // Priority merge of stall sources
  // ---------------------------------------------------------------------
  always_comb begin
    ctrl = '0;
    if (rst) begin
      ctrl = '0;
    end else if (state_q == ST_HALT) begin
      ctrl.sf = 1'b1; ctrl.sd = 1'b1; ctrl.se = 1'b1; ctrl.sm = 1'b1;
    end else if (mem_wait) begin
      // Whole pipe frozen; WB gets a NOP so the stalled MEM result
      // is not retired twice.
      ctrl.sf = 1'b1; ctrl.sd = 1'b1; ctrl.se = 1'b1; ctrl.sm = 1'b1;
      ctrl.bw = 1'b1;
    end else if (ex_busy) begin
      ctrl.sf = 1'b1; ctrl.sd = 1'b1; ctrl.se = 1'b1;
      ctrl.bm = 1'b1;
    end else if (branch_mispredict) begin
      // Wrong-path IF/ID contents are squashed, so a decode hazard on
      // them is irrelevant.
      ctrl.ff = 1'b1; ctrl.fd = 1'b1;
    end else if (is_data_hazard) begin
      ctrl.sf = 1'b1; ctrl.sd = 1'b1;
      ctrl.be = 1'b1;
    end
  end

  assign stall_fetch      = ctrl.sf;
  assign stall_decode     = ctrl.sd;
  assign stall_execute    = ctrl.se;
  assign stall_memory     = ctrl.sm;
  assign bubble_execute   = ctrl.be;
  assign bubble_memory    = ctrl.bm;
  assign bubble_writeback = ctrl.bw;
  assign flush_fetch      = ctrl.ff;
  assign flush_decode     = ctrl.fd;

  // ---------------------------------------------------------------------
  // FSM + memory-wait watchdog
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      wait_cnt_q     <= '0;
      dmem_timeout_q <= 1'b0;
    end else begin
      if (!mem_wait)
        wait_cnt_q <= '0;
      else if (wait_cnt_q != WAIT_MAX)
        wait_cnt_q <= wait_cnt_q + 1'b1;

      unique case (state_q)
        ST_RUN: begin
          if (halt_trig) begin
            state_q        <= ST_HALT;
            dmem_timeout_q <= 1'b1;
          end else if (muldiv_start & ~muldiv_done & ~mem_wait) begin
            // With mem_wait the whole pipe is held, so the start is
            // simply seen again next cycle.
            state_q <= ST_MD_WAIT;
          end
        end
        ST_MD_WAIT: begin
          if (halt_trig) begin
            state_q        <= ST_HALT;
            dmem_timeout_q <= 1'b1;
          end else if (muldiv_done & ~mem_wait) begin
            state_q <= ST_RUN;
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign dmem_timeout = dmem_timeout_q;

  // ---------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (ctrl.sf && (stall_cycles_q != '1))
        stall_cycles_q <= stall_cycles_q + 1'b1;
      if (ctrl.ff && (flush_events_q != '1))
        flush_events_q <= flush_events_q + 1'b1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
module tb_pipeline_stall_controller;

  localparam int TMO = 4;
  localparam int CW  = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, hz, bm, ms, md, rq, ak;
  logic sf, sd, se, sm, be, bmm, bw, ff, fd, tmo;
  logic [CW-1:0] scyc, fev;

  int checks = 0;
  int errors = 0;

  // Reference state, expressed as abstract facts rather than an encoding.
  bit m_halted;      // watchdog has fired since last reset
  bit m_md_out;      // a mul/div is outstanding across cycles
  int m_wait_run;    // length of the current run of wait cycles
  int m_stalls;
  int m_flushes;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.DMEM_TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .is_data_hazard(hz), .branch_mispredict(bm),
    .muldiv_start(ms), .muldiv_done(md),
    .dmem_req(rq), .dmem_ack(ak),
    .stall_fetch(sf), .stall_decode(sd), .stall_execute(se), .stall_memory(sm),
    .bubble_execute(be), .bubble_memory(bmm), .bubble_writeback(bw),
    .flush_fetch(ff), .flush_decode(fd),
    .dmem_timeout(tmo), .stall_cycles(scyc), .flush_events(fev)
  );

  // Expected control vector {sf,sd,se,sm,be,bm,bw,ff,fd} from the rules.
  function automatic logic [8:0] model_ctrl();
    bit mw = rq && !ak;
    bit busy = !md && (m_md_out || ms);
    if (rst)        return 9'b0000_000_00;
    if (m_halted)   return 9'b1111_000_00;
    if (mw)         return 9'b1111_001_00;
    if (busy)       return 9'b1110_010_00;
    if (bm)         return 9'b0000_000_11;
    if (hz)         return 9'b1100_100_00;
    return 9'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check everything against the model, then
  // advance the model to the state it will hold after the coming edge.
  task automatic step(input logic r, input logic h, input logic b,
                      input logic s, input logic d, input logic q, input logic a);
    logic [8:0] exp_c;
    bit mw;
    @(negedge clk);
    rst = r; hz = h; bm = b; ms = s; md = d; rq = q; ak = a;
    #1;
    exp_c = model_ctrl();
    chk("ctrl", {23'd0, sf, sd, se, sm, be, bmm, bw, ff, fd}, {23'd0, exp_c});
    chk("stall_cycles", {28'd0, scyc}, m_stalls);
    chk("flush_events", {28'd0, fev}, m_flushes);
    chk("dmem_timeout", {31'd0, tmo}, {31'd0, m_halted});
    mw = rq && !ak;
    if (r) begin
      m_halted = 0; m_md_out = 0; m_wait_run = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (exp_c[8] && m_stalls < CNT_MAX) m_stalls++;
      if (exp_c[1] && m_flushes < CNT_MAX) m_flushes++;
      if (!m_halted) begin
        if (mw) begin
          m_wait_run++;
          if (m_wait_run >= TMO) m_halted = 1;
        end else begin
          m_wait_run = 0;
          // Outstanding op ends on done; a new op starts if not done now.
          m_md_out = m_md_out ? !d : (s && !d);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; hz = 0; bm = 0; ms = 0; md = 0; rq = 0; ak = 0;
    m_halted = 0; m_md_out = 0; m_wait_run = 0; m_stalls = 0; m_flushes = 0;

    // Reset
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 1, 0);   // controls forced low during reset
    idle(1);

    // Data hazard for 2 cycles
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    idle(1);
    chk("hazard_stall_cnt", {28'd0, scyc}, 32'd2);

    // Multi-cycle mul/div: start held cycles 0-5, done at cycle 5
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    idle(1);
    // Single-cycle mul/div
    step(0, 0, 0, 1, 1, 0, 0);
    idle(1);

    // Mispredict beats data hazard
    step(0, 1, 1, 0, 0, 0, 0);
    idle(1);
    chk("flush_once", {28'd0, fev}, 32'd1);

    // Mispredict during mem wait: deferred to ack cycle
    step(0, 0, 1, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 1, 1);
    idle(1);
    chk("flush_deferred", {28'd0, fev}, 32'd2);

    // Memory wait inside MD_WAIT, done arrives mid-wait
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0, 0);   // wait clears: exits MD_WAIT here
    idle(1);

    // Ack on the 4th wait cycle: no HALT
    for (int i = 0; i < TMO - 1; i++) step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    idle(2);
    chk("no_halt", {31'd0, tmo}, 32'd0);

    // Four wait cycles -> HALT, sticky
    for (int i = 0; i < TMO; i++) step(0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 1, 1, 1, 0, 0);
    chk("halt_flag", {31'd0, tmo}, 32'd1);
    chk("halt_stall_all", {28'd0, sf, sd, se, sm}, 32'hf);
    idle(3);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("reset_counters", {24'd0, scyc, fev}, 32'd0);

    // Saturation of stall_cycles
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 0, 0);
    idle(1);
    chk("stall_saturate", {28'd0, scyc}, CNT_MAX);

    // Reset in the middle of MD_WAIT
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    idle(2);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++)
      step(($urandom % 60) == 0, ($urandom % 3) == 0, ($urandom % 5) == 0,
           ($urandom % 3) == 0, ($urandom % 3) == 0,
           ($urandom % 2) == 0, ($urandom % 2) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
